// File: rtl/axicb_mst_switch_wr.sv
// Per-slave write switch: AW arbitration, grant FIFO for W ordering, B routing by ID.
// Define AXICB_MST_WR_RR_EN for round-robin AW arbitration; default is fixed priority.
module axicb_mst_switch_wr #(
  parameter int                  AXI_ID_W       = 8,
  parameter int                  MST_NB         = 4,
  parameter logic [AXI_ID_W-1:0] MST0_ID_MASK   = 'h00,
  parameter logic [AXI_ID_W-1:0] MST1_ID_MASK   = 'h10,
  parameter logic [AXI_ID_W-1:0] MST2_ID_MASK   = 'h20,
  parameter logic [AXI_ID_W-1:0] MST3_ID_MASK   = 'h30,
  parameter logic [AXI_ID_W-1:0] ID_SEL_MASK    = 'h30,
  parameter int                  GNT_FIFO_DEPTH = 16,
  parameter int                  AWCH_W         = 8,
  parameter int                  WCH_W          = 8,
  parameter int                  BCH_W          = 10
) (
  input  logic                     aclk,
  input  logic                     srst,
  input  logic [MST_NB-1:0]        i_awvalid,
  output logic [MST_NB-1:0]        i_awready,
  input  logic [MST_NB*AWCH_W-1:0] i_awch,
  input  logic [MST_NB-1:0]        i_wvalid,
  output logic [MST_NB-1:0]        i_wready,
  input  logic [MST_NB-1:0]        i_wlast,
  input  logic [MST_NB*WCH_W-1:0]  i_wch,
  output logic [MST_NB-1:0]        i_bvalid,
  input  logic [MST_NB-1:0]        i_bready,
  output logic [BCH_W-1:0]         i_bch,
  output logic                     o_awvalid,
  input  logic                     o_awready,
  output logic [AWCH_W-1:0]        o_awch,
  output logic                     o_wvalid,
  input  logic                     o_wready,
  output logic                     o_wlast,
  output logic [WCH_W-1:0]         o_wch,
  input  logic                     o_bvalid,
  output logic                     o_bready,
  input  logic [BCH_W-1:0]         o_bch
);

  localparam int PW = $clog2(GNT_FIFO_DEPTH);
  localparam int CW = PW + 1;

  localparam logic [AXI_ID_W-1:0] ID_MASK [4] = '{
    MST0_ID_MASK, MST1_ID_MASK, MST2_ID_MASK, MST3_ID_MASK
  };

  typedef enum logic {
    IDLE,
    HOLD
  } aw_state_e;

  aw_state_e         state_q;
  logic [MST_NB-1:0] gnt_q;
  logic [MST_NB-1:0] arb_gnt;
  logic [MST_NB-1:0] aw_gnt;
  logic              aw_hs;

  logic [MST_NB-1:0] fifo_q [GNT_FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr_q;
  logic [PW-1:0]     rd_ptr_q;
  logic [CW-1:0]     cnt_q;
  logic              fifo_full;
  logic              fifo_empty;
  logic              push;
  logic              pop;
  logic [MST_NB-1:0] w_head;

  logic [MST_NB-1:0] b_sel;
  logic              b_hit;

`ifdef AXICB_MST_WR_RR_EN
  localparam int IW = (MST_NB > 1) ? $clog2(MST_NB) : 1;

  logic [IW-1:0]       rr_q;
  logic [IW-1:0]       aw_idx;
  logic [2*MST_NB-1:0] req_dbl;
  logic [2*MST_NB-1:0] gnt_dbl;
  logic [MST_NB-1:0]   req_rot;
  logic [MST_NB-1:0]   gnt_rot;

  // Rotate requests so the search starts at rr_q, then rotate the grant back.
  assign req_dbl = {i_awvalid, i_awvalid} >> rr_q;
  assign req_rot = req_dbl[MST_NB-1:0];
  assign gnt_rot = req_rot & (~req_rot + MST_NB'(1));
  assign gnt_dbl = {{MST_NB{1'b0}}, gnt_rot} << rr_q;
  assign arb_gnt = gnt_dbl[MST_NB-1:0] | gnt_dbl[2*MST_NB-1:MST_NB];

  always_comb begin
    aw_idx = '0;
    for (int m = 0; m < MST_NB; m++) begin
      if (aw_gnt[m]) aw_idx = aw_idx | IW'(m);
    end
  end

  always_ff @(posedge aclk) begin
    if (srst) begin
      rr_q <= '0;
    end else if (aw_hs) begin
      rr_q <= (aw_idx == IW'(MST_NB-1)) ? '0 : aw_idx + 1'b1;
    end
  end
`else
  assign arb_gnt = i_awvalid & (~i_awvalid + MST_NB'(1));
`endif

  always_comb begin
    aw_gnt = '0;
    unique case (state_q)
      IDLE:    aw_gnt = fifo_full ? '0 : arb_gnt;
      HOLD:    aw_gnt = gnt_q;
      default: aw_gnt = '0;
    endcase
  end

  assign o_awvalid = |aw_gnt;
  assign i_awready = aw_gnt & {MST_NB{o_awready}};
  assign aw_hs     = o_awvalid & o_awready;

  // Grant is frozen in HOLD so payload stays stable until the slave accepts.
  always_ff @(posedge aclk) begin
    if (srst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (o_awvalid && !o_awready) begin
            state_q <= HOLD;
            gnt_q   <= aw_gnt;
          end
        end
        HOLD: begin
          if (o_awready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign fifo_full  = (cnt_q == CW'(GNT_FIFO_DEPTH));
  assign fifo_empty = (cnt_q == '0);
  assign push       = aw_hs;
  assign pop        = o_wvalid & o_wready & o_wlast;

  always_ff @(posedge aclk) begin
    if (push) fifo_q[wr_ptr_q] <= aw_gnt;
  end

  always_ff @(posedge aclk) begin
    if (srst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign w_head   = fifo_empty ? '0 : fifo_q[rd_ptr_q];
  assign o_wvalid = |(w_head & i_wvalid);
  assign o_wlast  = |(w_head & i_wlast);
  assign i_wready = w_head & {MST_NB{o_wready}};

  always_comb begin
    o_awch = '0;
    o_wch  = '0;
    for (int m = 0; m < MST_NB; m++) begin
      o_awch = o_awch | (i_awch[m*AWCH_W +: AWCH_W] & {AWCH_W{aw_gnt[m]}});
      o_wch  = o_wch  | (i_wch[m*WCH_W +: WCH_W] & {WCH_W{w_head[m]}});
    end
  end

  always_comb begin
    b_sel = '0;
    b_hit = 1'b0;
    for (int m = 0; m < MST_NB; m++) begin
      if (!b_hit && ((o_bch[0 +: AXI_ID_W] & ID_SEL_MASK) == ID_MASK[m])) begin
        b_sel[m] = 1'b1;
        b_hit    = 1'b1;
      end
    end
  end

  // Unroutable responses are drained so the slave never stalls on them.
  assign i_bvalid = b_sel & {MST_NB{o_bvalid}};
  assign o_bready = b_hit ? |(b_sel & i_bready) : 1'b1;
  assign i_bch    = o_bch;

endmodule

// File: tb/tb_axicb_mst_switch_wr.sv
// Bench for axicb_mst_switch_wr: directed scenarios plus random traffic
// checked against a queue-based model of grants, W ordering and B routing.
module tb_axicb_mst_switch_wr;

  logic        aclk;
  logic        srst;
  logic [3:0]  aw_v, aw_r;
  logic [31:0] awch;
  logic [3:0]  w_v, w_r, w_l;
  logic [31:0] wch;
  logic [3:0]  b_v, b_rdy;
  logic [9:0]  ibch;
  logic        o_awvalid, o_awready;
  logic [7:0]  o_awch;
  logic        o_wvalid, o_wready, o_wlast;
  logic [7:0]  o_wch;
  logic        o_bvalid, o_bready;
  logic [9:0]  o_bch;

  int n_vec = 0;
  int n_err = 0;

  int q[$];
  int hold = -1;
  int ptr = 0;
  logic [3:0] hs_w;

  axicb_mst_switch_wr #(.ID_SEL_MASK(8'h70)) dut (
    .aclk(aclk), .srst(srst),
    .i_awvalid(aw_v), .i_awready(aw_r), .i_awch(awch),
    .i_wvalid(w_v), .i_wready(w_r), .i_wlast(w_l), .i_wch(wch),
    .i_bvalid(b_v), .i_bready(b_rdy), .i_bch(ibch),
    .o_awvalid(o_awvalid), .o_awready(o_awready), .o_awch(o_awch),
    .o_wvalid(o_wvalid), .o_wready(o_wready), .o_wlast(o_wlast),
    .o_wch(o_wch),
    .o_bvalid(o_bvalid), .o_bready(o_bready), .o_bch(o_bch)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int pick(input logic [3:0] req);
    for (int k = 0; k < 4; k++)
      if (req[(ptr + k) % 4]) return (ptr + k) % 4;
    return -1;
  endfunction

  // Compare current outputs with the model, then advance one clock.
  task automatic cycle();
    int g, h, bm;
    logic popm;
    g = (hold >= 0) ? hold : ((q.size() < 16) ? pick(aw_v) : -1);
    check("awvalid", 32'(o_awvalid), 32'(g >= 0));
    check("awready", 32'(aw_r),
          (g >= 0 && o_awready) ? (32'd1 << g) : 32'd0);
    if (g >= 0) check("awch", 32'(o_awch), 32'(awch[g*8 +: 8]));
    popm = 1'b0;
    if (q.size() > 0) begin
      h = q[0];
      check("wvalid", 32'(o_wvalid), 32'(w_v[h]));
      check("wready", 32'(w_r), o_wready ? (32'd1 << h) : 32'd0);
      check("wlast", 32'(o_wlast), 32'(w_l[h]));
      check("wch", 32'(o_wch), 32'(wch[h*8 +: 8]));
      popm = w_v[h] && o_wready && w_l[h];
    end else begin
      check("wvalid", 32'(o_wvalid), 32'd0);
      check("wready", 32'(w_r), 32'd0);
    end
    bm = -1;
    for (int m = 3; m >= 0; m--)
      if (32'(o_bch[7:0] & 8'h70) == 32'(m * 16)) bm = m;
    check("bvalid", 32'(b_v),
          (o_bvalid && bm >= 0) ? (32'd1 << bm) : 32'd0);
    check("bready", 32'(o_bready), (bm >= 0) ? 32'(b_rdy[bm]) : 32'd1);
    check("bch", 32'(ibch), 32'(o_bch));
    hs_w = w_r & w_v;
    @(posedge aclk);
    if (srst) begin
      q.delete();
      hold = -1;
      ptr = 0;
    end else begin
      if (popm) void'(q.pop_front());
      if (g >= 0) begin
        if (o_awready) begin
          q.push_back(g);
          hold = -1;
`ifdef AXICB_MST_WR_RR_EN
          ptr = (g + 1) % 4;
`endif
        end else begin
          hold = g;
        end
      end
    end
    @(negedge aclk);
  endtask

  task automatic idle_inputs();
    aw_v = '0; awch = $urandom; o_awready = 1'b0;
    w_v = '0; w_l = '0; wch = $urandom; o_wready = 1'b0;
    o_bvalid = 1'b0; o_bch = 10'h3ff; b_rdy = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    srst = 1'b1;
    #2; cycle();
    #2; cycle();
    srst = 1'b0;
  endtask

  int beat[4];
  logic [7:0] wexp[8];

  initial begin
    srst = 1'b1;
    idle_inputs();
    @(negedge aclk);
    do_reset();

    // Reset state: nothing forwarded even with W offered.
    w_v = 4'hf; w_l = 4'hf; o_wready = 1'b1; #2;
    check("rst_awvalid", 32'(o_awvalid), 32'd0);
    check("rst_wvalid", 32'(o_wvalid), 32'd0);
    check("rst_wready", 32'(w_r), 32'd0);
    check("rst_awready", 32'(aw_r), 32'd0);
    cycle();

    // Masters 0 and 2 contend.
    do_reset();
    aw_v = 4'b0101; o_awready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #2;
`ifdef AXICB_MST_WR_RR_EN
      check("arb_rr", 32'(aw_r), (i % 2 == 0) ? 32'h1 : 32'h4);
`else
      check("arb_fixed", 32'(aw_r), 32'h1);
`endif
      cycle();
    end

    // Grant held while slave stalls.
    do_reset();
    aw_v = 4'b0010; awch = 32'h0000_11aa; o_awready = 1'b0;
    #2; cycle();
    aw_v = 4'b0011;
    for (int i = 0; i < 3; i++) begin
      #2;
      check("hold_awch", 32'(o_awch), 32'h11);
      check("hold_awready", 32'(aw_r), 32'h0);
      cycle();
    end
    o_awready = 1'b1; #2;
    check("hold_release", 32'(aw_r), 32'h2);
    check("hold_rel_awch", 32'(o_awch), 32'h11);
    cycle();

    // Fill grant FIFO, then free one slot with a wlast.
    do_reset();
    aw_v = 4'b0001; o_awready = 1'b1;
    for (int i = 0; i < 16; i++) begin #2; cycle(); end
    #2;
    check("full_block", 32'(o_awvalid), 32'd0);
    cycle();
    w_v = 4'b0001; w_l = 4'b0001; o_wready = 1'b1; #2;
    check("full_pop_aw", 32'(o_awvalid), 32'd0);
    check("full_pop_wv", 32'(o_wvalid), 32'd1);
    cycle();
    w_v = '0; #2;
    check("after_pop", 32'(o_awvalid), 32'd1);
    cycle();

    // W ordering follows AW grant order: master 3 then master 1.
    do_reset();
    o_awready = 1'b1;
    aw_v = 4'b1000; #2; cycle();
    aw_v = 4'b0010; #2; cycle();
    aw_v = 4'b0000;
    beat = '{0, 0, 0, 0};
    wexp = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h10, 8'h11, 8'h12, 8'h13};
    o_wready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      wch = '0;
      wch[31:24] = 8'(8'h30 + beat[3]);
      wch[15:8]  = 8'(8'h10 + beat[1]);
      w_v = {beat[3] < 4, 1'b0, beat[1] < 4, 1'b0};
      w_l = {beat[3] == 3, 1'b0, beat[1] == 3, 1'b0};
      #2;
      check("word_order", 32'(o_wch), 32'(wexp[i]));
      cycle();
      for (int m = 0; m < 4; m++) if (hs_w[m]) beat[m]++;
    end
    w_v = '0; #2;
    check("word_drain", 32'(o_wvalid), 32'd0);
    cycle();

    // B routing.
    o_bvalid = 1'b1; o_bch = 10'h025; b_rdy = 4'hf; #2;
    check("b25_valid", 32'(b_v), 32'h4);
    check("b25_ready", 32'(o_bready), 32'd1);
    cycle();
    b_rdy = 4'b1011; #2;
    check("b25_stall", 32'(o_bready), 32'd0);
    cycle();
    o_bch = 10'h045; b_rdy = 4'h0; #2;
    check("b45_valid", 32'(b_v), 32'h0);
    check("b45_ready", 32'(o_bready), 32'd1);
    cycle();
    o_bvalid = 1'b0;

    // Reset in the middle of a burst with two grants queued.
    do_reset();
    o_awready = 1'b1;
    aw_v = 4'b0001; #2; cycle();
    aw_v = 4'b0010; #2; cycle();
    aw_v = 4'b0000; w_v = 4'b0001; w_l = 4'b0000; o_wready = 1'b1;
    #2; cycle();
    srst = 1'b1; #2; cycle();
    srst = 1'b0; w_v = 4'hf; w_l = 4'hf; #2;
    check("srst_wvalid", 32'(o_wvalid), 32'd0);
    check("srst_wready", 32'(w_r), 32'd0);
    check("srst_awvalid", 32'(o_awvalid), 32'd0);
    cycle();

    // Random traffic.
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      srst = ($urandom_range(0, 299) == 0);
      aw_v = 4'($urandom);
      awch = $urandom;
      o_awready = ($urandom_range(0, 3) != 0);
      w_v = 4'($urandom);
      w_l = {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
             ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)};
      wch = $urandom;
      o_wready = ($urandom_range(0, (i / 1000) % 2 == 0 ? 1 : 7) == 0);
      o_bvalid = 1'($urandom);
      o_bch = {2'($urandom), 1'($urandom_range(0, 4) == 0), 3'($urandom), 4'($urandom)};
      b_rdy = 4'($urandom);
      #2; cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
